// File: rtl/transform_wcnt.sv
// rtl/transform_wcnt.sv - x-direction row sweeper (w outer, kw inner) feeding the conv h-counter.
// Optional WCNT_PAD_SKIP_EN: pad positions are swept silently instead of being presented as beats.
module transform_wcnt #(
  parameter int C_W_WIDTH = 10,
  parameter int C_KWIDTH  = 4,
  parameter int C_SWIDTH  = 2,
  parameter int C_PWIDTH  = 2,
  parameter int C_HGAP    = 3
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_ap_start,
  input  logic                 I_compute_en,
  input  logic [C_W_WIDTH-1:0] I_owidth,
  input  logic [C_W_WIDTH-1:0] I_iwidth,
  input  logic [C_KWIDTH-1:0]  I_kernel_w,
  input  logic [C_SWIDTH-1:0]  I_stride_w,
  input  logic [C_PWIDTH-1:0]  I_pad_w,
  input  logic                 I_ready,
  output logic                 O_valid,
  output logic [C_W_WIDTH-1:0] O_w,
  output logic [C_KWIDTH-1:0]  O_kw,
  output logic [C_W_WIDTH:0]   O_windex,
  output logic                 O_pad_zero,
  output logic                 O_hcnt_flag,
  output logic                 O_busy,
  output logic                 O_done
);
  localparam int C_XW = C_W_WIDTH + 1;
  localparam int C_GW = $clog2(C_HGAP + 1);
  localparam logic [C_KWIDTH-1:0]  KW_ONE = 1;
  localparam logic [C_W_WIDTH-1:0] W_ONE  = 1;

  typedef enum logic [2:0] {S_IDLE, S_WAITH, S_RUN, S_GAP, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic                 r_start_d1;
  logic [C_W_WIDTH-1:0] r_w, r_xbase;
  logic [C_KWIDTH-1:0]  r_kw;
  logic                 r_all;
  logic [C_GW-1:0]      r_gap;
  logic                 r_valid, r_hcnt_flag, r_done;
  logic [C_W_WIDTH-1:0] r_o_w;
  logic [C_KWIDTH-1:0]  r_o_kw;
  logic [C_XW-1:0]      r_o_windex;

  logic            w_start_rise, w_in_run, w_slot_free, w_row_end;
  logic            w_load, w_advance, w_last_kw, w_last_w, w_degen, w_cur_pad;
  logic [C_XW-1:0] w_windex;

  assign w_start_rise = I_ap_start & ~r_start_d1;
  assign w_in_run     = (r_state == S_RUN);
  assign w_windex     = {1'b0, r_xbase} + C_XW'(r_kw) - C_XW'(I_pad_w);
  assign w_cur_pad    = w_windex[C_W_WIDTH] | (w_windex >= {1'b0, I_iwidth});
  assign w_slot_free  = ~r_valid | I_ready;
  // r_all marks that the row's last position has already been issued.
  assign w_row_end    = w_in_run & r_all & w_slot_free;
  assign w_last_kw    = (r_kw == I_kernel_w - KW_ONE);
  assign w_last_w     = (r_w == I_owidth - W_ONE);
  assign w_degen      = (I_owidth == '0) | (I_kernel_w == '0);

`ifdef WCNT_PAD_SKIP_EN
  // Pad positions step one per cycle without touching the output slot.
  assign w_load    = w_in_run & ~r_all & w_slot_free & ~w_cur_pad;
  assign w_advance = w_in_run & ~r_all & (w_slot_free | w_cur_pad);
  assign O_pad_zero = 1'b0;
`else
  logic r_pad;
  assign w_load    = w_in_run & ~r_all & w_slot_free;
  assign w_advance = w_load;
  assign O_pad_zero = r_pad;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_WAITH: begin
        if (w_degen)           w_state_nxt = S_DONE;
        else if (I_compute_en) w_state_nxt = S_RUN;
      end
      S_RUN:   if (w_row_end) w_state_nxt = S_GAP;
      S_GAP:   if (r_gap == C_GW'(C_HGAP)) w_state_nxt = I_compute_en ? S_RUN : S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_start_rise) w_state_nxt = S_WAITH;
  end

  always_ff @(posedge I_clk) begin
    r_start_d1 <= I_rst ? 1'b0 : I_ap_start;
    if (I_rst || w_start_rise) begin
      r_w         <= '0;
      r_kw        <= '0;
      r_xbase     <= '0;
      r_all       <= 1'b0;
      r_gap       <= '0;
      r_valid     <= 1'b0;
      r_hcnt_flag <= 1'b0;
      r_done      <= 1'b0;
      r_o_w       <= '0;
      r_o_kw      <= '0;
      r_o_windex  <= '0;
`ifndef WCNT_PAD_SKIP_EN
      r_pad       <= 1'b0;
`endif
    end else begin
      r_hcnt_flag <= w_row_end;
      r_done      <= (w_state_nxt == S_DONE);
      r_gap       <= (r_state == S_GAP) ? r_gap + C_GW'(1) : '0;
      if (w_row_end) r_all <= 1'b0;
      if (w_advance) begin
        if (w_last_kw) begin
          r_kw <= '0;
          if (w_last_w) begin
            r_w     <= '0;
            r_xbase <= '0;
            r_all   <= 1'b1;
          end else begin
            r_w     <= r_w + W_ONE;
            r_xbase <= r_xbase + C_W_WIDTH'(I_stride_w);
          end
        end else begin
          r_kw <= r_kw + KW_ONE;
        end
      end
      if (w_load) begin
        r_valid    <= 1'b1;
        r_o_w      <= r_w;
        r_o_kw     <= r_kw;
        r_o_windex <= w_windex;
`ifndef WCNT_PAD_SKIP_EN
        r_pad      <= w_cur_pad;
`endif
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign O_valid     = r_valid;
  assign O_w         = r_o_w;
  assign O_kw        = r_o_kw;
  assign O_windex    = r_o_windex;
  assign O_hcnt_flag = r_hcnt_flag;
  assign O_done      = r_done;
  assign O_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
endmodule
